// File: rtl/aes_dec_stream_ctrl.sv
// rtl/aes_dec_stream_ctrl.sv - byte-stream collect/settle/emit controller around the inv_aes core
module aes_dec_stream_ctrl #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   in_data,
  input  logic         in_is_key,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [7:0]   out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] dec_cipher_o,
  output logic [127:0] dec_key_o,
  input  logic [127:0] dec_plain_i,
  output logic         key_loaded,
  output logic         busy,
  output logic         err_proto
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SETTLE  = 2'd1,
    EMIT    = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [3:0]    byte_cnt;
  logic [3:0]    emit_cnt;
  logic [SW-1:0] settle_cnt;
  logic          grp_is_key;
  logic [119:0]  col_shift;
  logic [127:0]  out_shift;

  logic          in_fire;
  logic          out_fire;
  logic          mix_err;
  logic          nokey_err;
  logic          byte_ok;
  logic          grp_done;
  logic          settle_done;
  logic          emit_done;
  logic [127:0]  col_next;

  // Key and ciphertext groups never overlap, so one collection shift register serves both.
  assign col_next    = {col_shift, in_data};
  assign in_fire     = in_valid && in_ready;
  assign out_fire    = out_valid && out_ready;
  assign mix_err     = (byte_cnt != 4'd0) && (in_is_key != grp_is_key);
  assign nokey_err   = !in_is_key && !key_loaded;
  assign byte_ok     = in_fire && !mix_err && !nokey_err;
  assign grp_done    = byte_ok && (byte_cnt == 4'd15);
  assign settle_done = (state == SETTLE) && (settle_cnt == SETTLE_LAST);
  assign emit_done   = out_fire && (emit_cnt == 4'd15);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= COLLECT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (grp_done && !in_is_key) state_nxt = SETTLE;
      SETTLE:  if (settle_done) state_nxt = EMIT;
      EMIT:    if (emit_done) state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    if (rst_n) begin
      in_ready  = (state == COLLECT);
      out_valid = (state == EMIT);
    end
    out_data  = out_shift[127:120];
    busy      = (state != COLLECT) || (byte_cnt != 4'd0);
    err_proto = in_fire && (mix_err || nokey_err);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_cnt     <= 4'd0;
      emit_cnt     <= 4'd0;
      settle_cnt   <= '0;
      grp_is_key   <= 1'b0;
      col_shift    <= '0;
      out_shift    <= '0;
      dec_cipher_o <= '0;
      dec_key_o    <= '0;
      key_loaded   <= 1'b0;
    end else begin
      // A rejected byte throws away the partial group; committed key/cipher stay as they were.
      if (err_proto) begin
        byte_cnt <= 4'd0;
      end else if (byte_ok) begin
        byte_cnt  <= byte_cnt + 4'd1;
        col_shift <= col_next[119:0];
        if (byte_cnt == 4'd0) grp_is_key <= in_is_key;
        if (grp_done) begin
          if (in_is_key) begin
            dec_key_o  <= col_next;
            key_loaded <= 1'b1;
          end else begin
            dec_cipher_o <= col_next;
          end
        end
      end

      if (grp_done && !in_is_key) begin
        settle_cnt <= '0;
      end else if (state == SETTLE) begin
        settle_cnt <= settle_cnt + 1'b1;
      end

      if (settle_done) begin
        out_shift <= dec_plain_i;
        emit_cnt  <= 4'd0;
      end else if (out_fire) begin
        out_shift <= {out_shift[119:0], 8'h00};
        emit_cnt  <= emit_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_aes_dec_stream_ctrl.sv
// tb/tb_aes_dec_stream_ctrl.sv - self-checking bench for aes_dec_stream_ctrl
module tb_aes_dec_stream_ctrl;

  localparam int SETTLE = 4;
  localparam int BOUND  = 2000;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   in_data = 8'h00;
  logic         in_is_key = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] dec_cipher_o;
  logic [127:0] dec_key_o;
  logic [127:0] dec_plain_i;
  logic         key_loaded;
  logic         busy;
  logic         err_proto;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int err_cnt = 0;
  int first_valid_cyc = -1;
  int last_acc_cyc = 0;
  int ready_pct = 100;
  bit hold_low = 1'b0;
  logic prev_valid = 1'b0;
  logic [7:0] out_q[$];
  logic [7:0] exp_q[$];

  typedef struct packed {
    logic [7:0] d;
    logic       k;
    logic       v;
    logic       rdy;
    logic       err;
    logic       bsy;
    logic       kl;
  } step_t;
  step_t tbl[$];

  typedef struct packed {
    logic [7:0] d;
    logic       k;
  } item_t;
  item_t items[$];

  // reference model state
  logic [7:0]   m_buf[16];
  int           m_cnt = 0;
  logic         m_grp = 1'b0;
  logic         m_kl = 1'b0;
  logic [127:0] m_key = '0;
  int           m_err = 0;

  aes_dec_stream_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_is_key(in_is_key), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .dec_cipher_o(dec_cipher_o), .dec_key_o(dec_key_o), .dec_plain_i(dec_plain_i),
    .key_loaded(key_loaded), .busy(busy), .err_proto(err_proto)
  );

  // Stand-in for the combinational core: the FIPS-197 C.1 pair plus an arbitrary mix otherwise.
  function automatic logic [127:0] core_fn(input logic [127:0] ct, input logic [127:0] key);
    if (ct == FIPS_CT && key == FIPS_KEY) return FIPS_PT;
    return ct ^ {key[63:0], key[127:64]} ^ 128'hc3a5_5a3c_0ff0_1234_8765_fedc_ba98_7e1d;
  endfunction

  function automatic logic [7:0] byte_of(input logic [127:0] b, input int i);
    return b[127-8*i -: 8];
  endfunction

  assign dec_plain_i = core_fn(dec_cipher_o, dec_key_o);

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always begin
    @(posedge clk);
    #1;
    out_ready = !hold_low && (int'($urandom_range(99)) < ready_pct);
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) out_q.push_back(out_data);
      if (err_proto) err_cnt++;
      if (out_valid && !prev_valid) first_valid_cyc = cyc;
    end
    prev_valid = out_valid;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic k);
    int t;
    logic acc;
    t = 0;
    acc = 1'b0;
    in_data = d;
    in_is_key = k;
    in_valid = 1'b1;
    while (!acc && t < BOUND) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) last_acc_cyc = cyc;
      tick();
      t++;
    end
    check("send_accept", 128'(acc), 128'(1));
    in_valid = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] blk, input logic k);
    for (int i = 0; i < 16; i++) send(byte_of(blk, i), k);
  endtask

  task automatic add_exp(input logic [127:0] blk);
    for (int i = 0; i < 16; i++) exp_q.push_back(byte_of(blk, i));
  endtask

  task automatic clear_obs();
    out_q.delete();
    exp_q.delete();
    err_cnt = 0;
  endtask

  task automatic wait_out(input int n, input string name);
    int t;
    t = 0;
    while (out_q.size() < n && t < BOUND) begin
      tick();
      t++;
    end
    check(name, 128'(out_q.size()), 128'(n));
  endtask

  task automatic check_bytes(input string name);
    check({name, "_count"}, 128'(out_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
      check(name, 128'(out_q[i]), 128'(exp_q[i]));
  endtask

  // Returns at the negedge before the edge on which the n-th output transfer completes.
  task automatic wait_transfers(input int n, input string name);
    int seen;
    int t;
    seen = 0;
    t = 0;
    while (seen < n && t < BOUND) begin
      @(negedge clk);
      if (out_valid && out_ready) seen++;
      t++;
    end
    check(name, 128'(seen), 128'(n));
  endtask

  task automatic add_step(input logic [7:0] d, input logic k, input logic v,
                          input logic err, input logic bsy, input logic kl);
    step_t s;
    s.d = d; s.k = k; s.v = v; s.rdy = 1'b1; s.err = err; s.bsy = bsy; s.kl = kl;
    tbl.push_back(s);
  endtask

  task automatic model_byte(input logic [7:0] d, input logic k);
    logic [127:0] blk;
    if ((m_cnt != 0 && k != m_grp) || (!k && !m_kl)) begin
      m_err++;
      m_cnt = 0;
    end else begin
      if (m_cnt == 0) m_grp = k;
      m_buf[m_cnt] = d;
      m_cnt++;
      if (m_cnt == 16) begin
        for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = m_buf[i];
        if (k) begin
          m_key = blk;
          m_kl = 1'b1;
        end else begin
          add_exp(core_fn(blk, m_key));
        end
        m_cnt = 0;
      end
    end
  endtask

  initial begin
    logic [127:0] ct2;
    logic [127:0] rnd;
    int r;
    int n;
    logic k;

    // test 1: reset with in_valid held high
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_is_key = 1'b1;
    in_data = 8'ha5;
    repeat (2) tick();
    @(negedge clk);
    check("rst_in_ready", 128'(in_ready), 128'(0));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_key_loaded", 128'(key_loaded), 128'(0));
    check("rst_key", dec_key_o, 128'(0));
    check("rst_cipher", dec_cipher_o, 128'(0));
    check("rst_out_data", 128'(out_data), 128'(0));
    check("rst_err", 128'(err_proto), 128'(0));
    tick();
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", 128'(in_ready), 128'(1));
    check("rel_busy", 128'(busy), 128'(0));
    tick();
    clear_obs();

    // tests 4, 2 (key part), key abort and 5 (mixed group), one row per cycle
    for (int i = 0; i < 3; i++) add_step(8'h10 + 8'(i), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    add_step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) add_step(byte_of(FIPS_KEY, i), 1'b1, 1'b1, 1'b0, i != 0, 1'b0);
    add_step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) add_step(8'hf0 + 8'(i), 1'b1, 1'b1, 1'b0, i != 0, 1'b1);
    add_step(8'h77, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    add_step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) add_step(8'h40 + 8'(i), 1'b0, 1'b1, 1'b0, i != 0, 1'b1);
    add_step(8'h99, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    add_step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < tbl.size(); i++) begin
      in_data = tbl[i].d;
      in_is_key = tbl[i].k;
      in_valid = tbl[i].v;
      @(negedge clk);
      check("tbl_in_ready", 128'(in_ready), 128'(tbl[i].rdy));
      check("tbl_err_proto", 128'(err_proto), 128'(tbl[i].err));
      check("tbl_busy", 128'(busy), 128'(tbl[i].bsy));
      check("tbl_key_loaded", 128'(key_loaded), 128'(tbl[i].kl));
      check("tbl_out_valid", 128'(out_valid), 128'(0));
      tick();
    end
    in_valid = 1'b0;
    check("tbl_key", dec_key_o, FIPS_KEY);
    check("tbl_err_total", 128'(err_cnt), 128'(5));
    check("tbl_no_output", 128'(out_q.size()), 128'(0));

    // test 2 / 5: FIPS-197 C.1 block and settle latency
    clear_obs();
    first_valid_cyc = -1;
    add_exp(FIPS_PT);
    send_block(FIPS_CT, 1'b0);
    wait_out(16, "fips_wait");
    check_bytes("fips_pt");
    check("fips_cipher", dec_cipher_o, FIPS_CT);
    check("fips_key_kept", dec_key_o, FIPS_KEY);
    check("fips_latency", 128'(first_valid_cyc - last_acc_cyc), 128'(SETTLE + 1));
    check("fips_no_err", 128'(err_cnt), 128'(0));
    tick();
    @(negedge clk);
    check("fips_done_in_ready", 128'(in_ready), 128'(1));
    check("fips_done_out_valid", 128'(out_valid), 128'(0));
    tick();

    // test 3: backpressure after the third output byte
    clear_obs();
    add_exp(FIPS_PT);
    send_block(FIPS_CT, 1'b0);
    wait_transfers(3, "bp_reach3");
    hold_low = 1'b1;
    tick();
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check("bp_out_valid", 128'(out_valid), 128'(1));
      check("bp_out_data", 128'(out_data), 128'(8'h33));
      check("bp_in_ready", 128'(in_ready), 128'(0));
      if (j == 4) hold_low = 1'b0;
      tick();
    end
    wait_out(16, "bp_wait");
    repeat (3) tick();
    check_bytes("bp_pt");

    // test 7: back-to-back blocks with in_valid held during settle/emit
    clear_obs();
    ct2 = {$urandom, $urandom, $urandom, $urandom};
    add_exp(FIPS_PT);
    add_exp(core_fn(ct2, FIPS_KEY));
    send_block(FIPS_CT, 1'b0);
    send_block(ct2, 1'b0);
    wait_out(32, "b2b_wait");
    repeat (3) tick();
    check_bytes("b2b_pt");
    check("b2b_no_err", 128'(err_cnt), 128'(0));

    // test 6: reset during emission
    clear_obs();
    send_block(FIPS_CT, 1'b0);
    wait_transfers(5, "rst_emit_reach5");
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_emit_out_valid", 128'(out_valid), 128'(0));
    check("rst_emit_in_ready", 128'(in_ready), 128'(0));
    tick();
    @(negedge clk);
    check("rst_emit_key_loaded", 128'(key_loaded), 128'(0));
    check("rst_emit_key", dec_key_o, 128'(0));
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    check("rst_emit_no_resume", 128'(out_q.size()), 128'(5));
    err_cnt = 0;
    rnd = {$urandom, $urandom, $urandom, $urandom};
    send_block(rnd, 1'b0);
    repeat (3) tick();
    check("rst_emit_errs", 128'(err_cnt), 128'(16));
    check("rst_emit_no_out", 128'(out_q.size()), 128'(5));
    check("rst_emit_busy", 128'(busy), 128'(0));

    // randomized traffic against the reference model (DUT is fresh after reset)
    clear_obs();
    items.delete();
    for (int g = 0; g < 24; g++) begin
      r = (g == 0) ? 0 : int'($urandom_range(9));
      rnd = {$urandom, $urandom, $urandom, $urandom};
      if (r <= 2 || r >= 8) k = (r <= 2) ? 1'b1 : 1'($urandom_range(1));
      else k = 1'b0;
      n = (r >= 8) ? int'($urandom_range(1, 15)) : 16;
      for (int i = 0; i < n; i++) items.push_back({byte_of(rnd, i), k});
      if (r >= 8) items.push_back({8'($urandom), !k});
    end
    for (int i = 0; i < items.size(); i++) model_byte(items[i].d, items[i].k);
    ready_pct = 60;
    for (int i = 0; i < items.size(); i++) begin
      repeat (int'($urandom_range(2))) tick();
      send(items[i].d, items[i].k);
    end
    wait_out(exp_q.size(), "rand_wait");
    repeat (4) tick();
    check_bytes("rand_pt");
    check("rand_errs", 128'(err_cnt), 128'(m_err));
    check("rand_key", dec_key_o, m_key);
    check("rand_key_loaded", 128'(key_loaded), 128'(m_kl));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
